// File: rtl/cache_control_pkg.sv
// Shared types and geometry for the 2-way set-associative L1 cache.
// Used by the sequencing FSM, its way decoder and the cache datapath.
package cache_types;

  localparam int NUM_WAYS    = 2;
  localparam int LINE_BITS   = 256;
  localparam int SET_BITS    = 3;
  localparam int OFFSET_BITS = 5;

  // Sequencing states of the cache controller.
  typedef enum logic [1:0] {
    HIT_CHECK = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  // With two ways, the LRU bit after an access names the way not just used.
  function automatic logic other_way(input logic way);
    return ~way;
  endfunction

endpackage

// File: rtl/cache_control_if.sv
// Bundle of CPU request, pmem handshake, datapath status and datapath
// control signals around the cache controller.
// master: the controller. slave: the CPU/pmem/datapath environment.
interface cache_control_if;

  // Requests and status into the controller
  logic mem_read;
  logic mem_write;
  logic hit0;
  logic hit1;
  logic dirty0;
  logic dirty1;
  logic lru;
  logic pmem_resp;

  // Responses and datapath controls out of the controller
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_addr_sel;
  logic data_sel;
  logic way_sel;
  logic load_data0;
  logic load_data1;
  logic load_tag0;
  logic load_tag1;
  logic set_dirty0;
  logic set_dirty1;
  logic clr_dirty0;
  logic clr_dirty1;
  logic load_lru;
  logic lru_in;

  modport master (
    input  mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel, way_sel,
           load_data0, load_data1, load_tag0, load_tag1,
           set_dirty0, set_dirty1, clr_dirty0, clr_dirty1,
           load_lru, lru_in
  );

  modport slave (
    output mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel, way_sel,
           load_data0, load_data1, load_tag0, load_tag1,
           set_dirty0, set_dirty1, clr_dirty0, clr_dirty1,
           load_lru, lru_in
  );

endinterface

// File: rtl/cache_control_way_ctrl.sv
// Way decoder: turns way-agnostic array commands from the FSM into
// per-way strobes for the data, tag/valid and dirty arrays.
module cache_way_ctrl
  import cache_types::*;
(
  input  logic                way_i,
  input  logic                load_data_i,
  input  logic                load_tag_i,
  input  logic                set_dirty_i,
  input  logic                clr_dirty_i,
  output logic [NUM_WAYS-1:0] load_data_o,
  output logic [NUM_WAYS-1:0] load_tag_o,
  output logic [NUM_WAYS-1:0] set_dirty_o,
  output logic [NUM_WAYS-1:0] clr_dirty_o
);

  // One decode slice per way; a strobe fires only for the selected way.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    logic sel;
    assign sel            = (way_i == 1'(gi));
    assign load_data_o[gi] = load_data_i & sel;
    assign load_tag_o[gi]  = load_tag_i  & sel;
    assign set_dirty_o[gi] = set_dirty_i & sel;
    assign clr_dirty_o[gi] = clr_dirty_i & sel;
  end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM of the write-back/write-allocate L1 cache. Decides hit,
// writeback and allocate sequencing and drives the datapath's array and
// mux controls; it never sees data or addresses itself.
module cache_control
  import cache_types::*;
(
  input  logic            clk,
  input  logic            rst,
  cache_control_if.master bus
);

  state_t state_q, state_d;
  logic   victim_q, victim_d;   // way being evicted/refilled during a miss

  logic req, is_write, hit_any, hit_way, victim_dirty;

  // Way-agnostic controls produced by the FSM
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel, way_sel;
  logic load_data, load_tag, set_dirty, clr_dirty, load_lru, lru_in;

  logic [NUM_WAYS-1:0] load_data_w, load_tag_w, set_dirty_w, clr_dirty_w;

  // A simultaneous read+write is served as a write; a double hit goes to way 0.
  assign req          = bus.mem_read | bus.mem_write;
  assign is_write     = bus.mem_write;
  assign hit_any      = bus.hit0 | bus.hit1;
  assign hit_way      = bus.hit0 ? 1'b0 : 1'b1;
  assign victim_dirty = bus.lru ? bus.dirty1 : bus.dirty0;

  // State and latched victim register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HIT_CHECK;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Next state and Moore/Mealy control outputs
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_sel      = 1'b0;
    way_sel       = 1'b0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;

    case (state_q)
      HIT_CHECK: begin
        // pmem_resp is ignored here; only a CPU request moves the FSM.
        if (req) begin
          if (hit_any) begin
            mem_resp = 1'b1;
            way_sel  = hit_way;
            load_lru = 1'b1;
            lru_in   = other_way(hit_way);
            if (is_write) begin
              // data_sel stays 0: the merged CPU-write line is stored.
              load_data = 1'b1;
              set_dirty = 1'b1;
            end
          end else begin
            // Latch the victim now so a changing lru cannot redirect the miss.
            victim_d = bus.lru;
            state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (bus.pmem_resp) begin
          clr_dirty = 1'b1;
          state_d   = ALLOCATE;
        end
      end

      ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (bus.pmem_resp) begin
          // Refill: the request is retried from HIT_CHECK and then hits.
          data_sel  = 1'b1;
          load_data = 1'b1;
          load_tag  = 1'b1;
          clr_dirty = 1'b1;
          state_d   = HIT_CHECK;
        end
      end

      default: state_d = HIT_CHECK;
    endcase
  end

  cache_way_ctrl u_way_ctrl (
    .way_i       (way_sel),
    .load_data_i (load_data),
    .load_tag_i  (load_tag),
    .set_dirty_i (set_dirty),
    .clr_dirty_i (clr_dirty),
    .load_data_o (load_data_w),
    .load_tag_o  (load_tag_w),
    .set_dirty_o (set_dirty_w),
    .clr_dirty_o (clr_dirty_w)
  );

  assign bus.mem_resp      = mem_resp;
  assign bus.pmem_read     = pmem_read;
  assign bus.pmem_write    = pmem_write;
  assign bus.pmem_addr_sel = pmem_addr_sel;
  assign bus.data_sel      = data_sel;
  assign bus.way_sel       = way_sel;
  assign bus.load_data0    = load_data_w[0];
  assign bus.load_data1    = load_data_w[1];
  assign bus.load_tag0     = load_tag_w[0];
  assign bus.load_tag1     = load_tag_w[1];
  assign bus.set_dirty0    = set_dirty_w[0];
  assign bus.set_dirty1    = set_dirty_w[1];
  assign bus.clr_dirty0    = clr_dirty_w[0];
  assign bus.clr_dirty1    = clr_dirty_w[1];
  assign bus.load_lru      = load_lru;
  assign bus.lru_in        = lru_in;

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: directed steps with forced datapath status,
// then random traffic where a bench-side datapath (driven by the DUT's
// strobes) is compared against a transaction-level cache model.
module tb_cache_control;

  typedef struct packed {
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_addr_sel;
    logic       data_sel;
    logic       way_sel;
    logic [1:0] ld;
    logic [1:0] lt;
    logic [1:0] sd;
    logic [1:0] cd;
    logic       load_lru;
    logic       lru_in;
  } ov_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_control_if bus ();

  cache_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Forced status (directed steps) or bench datapath (random phase)
  logic ovr = 1'b1;
  logic ovr_hit0 = 1'b0, ovr_hit1 = 1'b0, ovr_dirty0 = 1'b0, ovr_dirty1 = 1'b0, ovr_lru = 1'b0;

  // Bench datapath arrays, written only by DUT strobes
  logic [2:0] cur_set = '0;
  logic [3:0] cur_tag = '0;
  logic       dp_clear = 1'b0;
  logic       dp_valid [2][8];
  logic       dp_dirty [2][8];
  logic [3:0] dp_tag   [2][8];
  logic       dp_lru   [8];

  // Reference cache state, updated per transaction
  logic       ref_valid [2][8];
  logic       ref_dirty [2][8];
  logic [3:0] ref_tag   [2][8];
  logic       ref_lru   [8];

  assign bus.hit0   = ovr ? ovr_hit0 : (dp_valid[0][cur_set] && dp_tag[0][cur_set] == cur_tag);
  assign bus.hit1   = ovr ? ovr_hit1 : (dp_valid[1][cur_set] && dp_tag[1][cur_set] == cur_tag);
  assign bus.dirty0 = ovr ? ovr_dirty0 : dp_dirty[0][cur_set];
  assign bus.dirty1 = ovr ? ovr_dirty1 : dp_dirty[1][cur_set];
  assign bus.lru    = ovr ? ovr_lru : dp_lru[cur_set];

  always @(posedge clk) begin
    if (dp_clear) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 8; s++) begin
          dp_valid[w][s] <= 1'b0;
          dp_dirty[w][s] <= 1'b0;
          dp_tag[w][s]   <= 4'd0;
        end
      for (int s = 0; s < 8; s++) dp_lru[s] <= 1'b0;
    end else begin
      if (bus.load_tag0) begin dp_tag[0][cur_set] <= cur_tag; dp_valid[0][cur_set] <= 1'b1; end
      if (bus.load_tag1) begin dp_tag[1][cur_set] <= cur_tag; dp_valid[1][cur_set] <= 1'b1; end
      if (bus.set_dirty0) dp_dirty[0][cur_set] <= 1'b1;
      if (bus.set_dirty1) dp_dirty[1][cur_set] <= 1'b1;
      if (bus.clr_dirty0) dp_dirty[0][cur_set] <= 1'b0;
      if (bus.clr_dirty1) dp_dirty[1][cur_set] <= 1'b0;
      if (bus.load_lru) dp_lru[cur_set] <= bus.lru_in;
    end
  end

  localparam ov_t ZERO     = '0;
  localparam ov_t MASK_ALL = '1;
  // way_sel has no specified value while refilling
  localparam ov_t MASK_AL  = ov_t'(~(16'h1 << 10));

  function automatic ov_t sample();
    ov_t o;
    o.mem_resp      = bus.mem_resp;
    o.pmem_read     = bus.pmem_read;
    o.pmem_write    = bus.pmem_write;
    o.pmem_addr_sel = bus.pmem_addr_sel;
    o.data_sel      = bus.data_sel;
    o.way_sel       = bus.way_sel;
    o.ld            = {bus.load_data1, bus.load_data0};
    o.lt            = {bus.load_tag1, bus.load_tag0};
    o.sd            = {bus.set_dirty1, bus.set_dirty0};
    o.cd            = {bus.clr_dirty1, bus.clr_dirty0};
    o.load_lru      = bus.load_lru;
    o.lru_in        = bus.lru_in;
    return o;
  endfunction

  // Expected outputs on a hit in way h
  function automatic ov_t hit_vec(input logic h, input logic wr);
    ov_t o = '0;
    o.mem_resp = 1'b1;
    o.way_sel  = h;
    o.load_lru = 1'b1;
    o.lru_in   = ~h;
    if (wr) begin o.ld[h] = 1'b1; o.sd[h] = 1'b1; end
    return o;
  endfunction

  // Expected outputs during writeback of victim v
  function automatic ov_t wb_vec(input logic v, input logic resp);
    ov_t o = '0;
    o.pmem_write    = 1'b1;
    o.pmem_addr_sel = 1'b1;
    o.way_sel       = v;
    if (resp) o.cd[v] = 1'b1;
    return o;
  endfunction

  // Expected outputs during refill of victim v
  function automatic ov_t al_vec(input logic v, input logic resp);
    ov_t o = '0;
    o.pmem_read = 1'b1;
    if (resp) begin o.data_sel = 1'b1; o.ld[v] = 1'b1; o.lt[v] = 1'b1; o.cd[v] = 1'b1; end
    return o;
  endfunction

  // Compare outputs mid-cycle, then advance to just after the next edge
  task automatic chk(input string nm, input ov_t exp, input ov_t msk);
    ov_t obs;
    @(negedge clk);
    obs = sample();
    total++;
    assert ((obs & msk) === (exp & msk))
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs & msk, exp & msk);
    end
    @(posedge clk);
    #1;
  endtask

  // Sequence one presented request: optional miss, writeback, refill, then hit
  task automatic run_txn(input string nm, input logic wr, input logic miss, input logic h,
                         input logic dirty, input int nw, input int na);
    if (miss) begin
      bus.pmem_resp = 1'b0;
      chk({nm, "_miss"}, ZERO, MASK_ALL);
      if (ovr) ovr_lru = ~ovr_lru;     // victim must stay latched
      if (dirty)
        for (int k = 0; k < nw; k++) begin
          bus.pmem_resp = (k == nw - 1);
          chk({nm, "_wb"}, wb_vec(h, k == nw - 1), MASK_ALL);
        end
      for (int k = 0; k < na; k++) begin
        bus.pmem_resp = (k == na - 1);
        chk({nm, "_al"}, al_vec(h, k == na - 1), MASK_AL);
      end
      bus.pmem_resp = 1'b0;
      if (ovr) begin ovr_hit0 = (h == 1'b0); ovr_hit1 = (h == 1'b1); end
    end
    chk({nm, "_hit"}, hit_vec(h, wr), MASK_ALL);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    int op, nw, na;
    logic wr, h0, h1, miss, h, dirty;
    logic [2:0] s;
    logic [3:0] t;
    logic [12:0] dp_st, ref_st;

    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_idle", ZERO, MASK_ALL);

    // Read hit in way 1, lru=1
    ovr_hit1 = 1'b1; ovr_lru = 1'b1; bus.mem_read = 1'b1;
    run_txn("rd_hit1", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    // Write hit in way 0
    ovr_hit0 = 1'b1; ovr_hit1 = 1'b0; bus.mem_write = 1'b1;
    run_txn("wr_hit0", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("idle0", ZERO, MASK_ALL);
    // Clean read miss, victim 0, refill takes 4 cycles
    ovr_hit0 = 1'b0; ovr_lru = 1'b0; ovr_dirty0 = 1'b0; bus.mem_read = 1'b1;
    run_txn("rd_miss", 1'b0, 1'b1, 1'b0, 1'b0, 0, 4);
    // Dirty write miss, victim 1, W=3 A=3
    ovr_hit0 = 1'b0; ovr_hit1 = 1'b0; ovr_lru = 1'b1; ovr_dirty1 = 1'b1; bus.mem_write = 1'b1;
    run_txn("wr_dmiss", 1'b1, 1'b1, 1'b1, 1'b1, 3, 3);
    // Reset in the second refill cycle; late pmem_resp must be ignored
    ovr_hit0 = 1'b0; ovr_hit1 = 1'b0; ovr_lru = 1'b0; ovr_dirty0 = 1'b0; bus.mem_read = 1'b1;
    chk("rst_miss", ZERO, MASK_ALL);
    chk("rst_al1", al_vec(1'b0, 1'b0), MASK_AL);
    rst = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0; bus.mem_read = 1'b0; bus.pmem_resp = 1'b1;
    chk("rst_late_resp", ZERO, MASK_ALL);
    bus.pmem_resp = 1'b0;
    ovr_hit1 = 1'b1; bus.mem_read = 1'b1;
    run_txn("rst_then_hit", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    // Double hit resolves to way 0
    ovr_hit0 = 1'b1; ovr_hit1 = 1'b1; bus.mem_read = 1'b1;
    run_txn("dbl_hit", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Random phase against a transaction-level cache model
    dp_clear = 1'b1;
    @(posedge clk); #1;
    dp_clear = 1'b0; ovr = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++) begin
        ref_valid[w][i] = 1'b0; ref_dirty[w][i] = 1'b0; ref_tag[w][i] = 4'd0;
      end
    for (int i = 0; i < 8; i++) ref_lru[i] = 1'b0;

    for (int n = 0; n < 80; n++) begin
      s  = 3'($urandom_range(0, 3));
      t  = 4'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      nw = $urandom_range(1, 3);
      na = $urandom_range(1, 3);
      wr = (op != 0);
      h0 = ref_valid[0][s] && ref_tag[0][s] == t;
      h1 = ref_valid[1][s] && ref_tag[1][s] == t;
      miss  = !(h0 || h1);
      h     = miss ? ref_lru[s] : !h0;
      dirty = miss && ref_dirty[h][s];
      $display("txn %0d op=%0d set=%0d tag=%0d %s way=%0d dirty=%0d W=%0d A=%0d",
               n, op, s, t, miss ? "miss" : "hit", h, dirty, nw, na);
      cur_set = s; cur_tag = t;
      bus.mem_read  = (op != 1);
      bus.mem_write = wr;
      run_txn("rnd", wr, miss, h, dirty, nw, na);
      if (miss) begin
        ref_tag[h][s] = t; ref_valid[h][s] = 1'b1; ref_dirty[h][s] = 1'b0;
      end
      ref_lru[s] = ~h;
      if (wr) ref_dirty[h][s] = 1'b1;
      dp_st  = {dp_valid[1][s], dp_valid[0][s], dp_dirty[1][s], dp_dirty[0][s],
                dp_lru[s], dp_tag[1][s], dp_tag[0][s]};
      ref_st = {ref_valid[1][s], ref_valid[0][s], ref_dirty[1][s], ref_dirty[0][s],
                ref_lru[s], ref_tag[1][s], ref_tag[0][s]};
      total++;
      assert (dp_st === ref_st)
      else begin
        bad++;
        $error("FAIL rnd_arrays observed=%h expected=%h", dp_st, ref_st);
      end
      if ($urandom_range(0, 1) == 1) chk("rnd_idle", ZERO, MASK_ALL);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
